// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | Shared op codes, flag bit positions and controller state encoding.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int OP_W    = 3;
    localparam int FLAGS_W = 4;
    localparam int STATE_W = 2;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SLL = 3'b100;
    localparam logic [OP_W-1:0] ALU_SRL = 3'b101;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_O = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes 110 and 111 are unassigned and reported as errors.
    function automatic logic op_is_invalid(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// +----------------------------------------------------------------------------+
// | alu                                                                        |
// | Combinational ALU: ADD/SUB/AND/OR/SLL/SRL with {Z,N,C,O} flags.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [OP_W-1:0]    op,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags
);

    localparam int c_shamt_w = $clog2(WIDTH);
    localparam int c_msb     = WIDTH - 1;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [c_shamt_w-1:0] w_shamt;
    logic                 w_c;
    logic                 w_o;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[c_shamt_w-1:0];

    // Invalid codes fall to the default arm: result 0, which yields flags 1000.
    always_comb begin
        result = '0;
        w_c    = 1'b0;
        w_o    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = w_sum[WIDTH-1:0];
                w_c    = w_sum[WIDTH];
                w_o    = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
            end
            ALU_SUB: begin
                result = w_diff[WIDTH-1:0];
                w_c    = ~w_diff[WIDTH];
                w_o    = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << w_shamt;
            ALU_SRL: result = a >> w_shamt;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (result == '0);
        flags[FLG_N] = result[c_msb];
        flags[FLG_C] = w_c;
        flags[FLG_O] = w_o;
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// +----------------------------------------------------------------------------+
// | alu_share_ctrl                                                             |
// | Two-port round-robin controller sharing one alu instance.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_0,
    input  logic               req_valid_1,
    output logic               req_ready_0,
    output logic               req_ready_1,
    input  logic [WIDTH-1:0]   req_a_0,
    input  logic [WIDTH-1:0]   req_b_0,
    input  logic [WIDTH-1:0]   req_a_1,
    input  logic [WIDTH-1:0]   req_b_1,
    input  logic [OP_W-1:0]    req_op_0,
    input  logic [OP_W-1:0]    req_op_1,
    output logic               resp_valid_0,
    output logic               resp_valid_1,
    input  logic               resp_ready_0,
    input  logic               resp_ready_1,
    output logic [WIDTH-1:0]   resp_result,
    output logic [FLAGS_W-1:0] resp_flags,
    output logic               resp_err,
    output logic               busy
);

    state_t             r_state;
    logic               r_owner;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [OP_W-1:0]    r_op;
    logic [WIDTH-1:0]   r_result;
    logic [FLAGS_W-1:0] r_flags;
    logic               r_err;
    logic               r_resp_valid_0;
    logic               r_resp_valid_1;
    logic               r_busy;

    logic               w_grant_0;
    logic               w_grant_1;
    logic               w_idle;
    logic               w_accept;
    logic               w_resp_take;
    logic [WIDTH-1:0]   w_alu_result;
    logic [FLAGS_W-1:0] w_alu_flags;

    // On conflict the port that did not win last time is favoured.
    assign w_grant_0 = req_valid_0 & (~req_valid_1 | r_last_grant);
    assign w_grant_1 = req_valid_1 & (~req_valid_0 | ~r_last_grant);

    // rst gating keeps ready low for the whole reset assertion, not just after it.
    assign w_idle      = (r_state == ST_IDLE) & ~rst;
    assign req_ready_0 = w_idle & w_grant_0;
    assign req_ready_1 = w_idle & w_grant_1;
    assign w_accept    = req_ready_0 | req_ready_1;
    assign w_resp_take = r_owner ? resp_ready_1 : resp_ready_0;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_owner        <= 1'b0;
            r_last_grant   <= 1'b1;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_result       <= '0;
            r_flags        <= '0;
            r_err          <= 1'b0;
            r_resp_valid_0 <= 1'b0;
            r_resp_valid_1 <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= req_ready_1 ? req_a_1  : req_a_0;
                        r_b          <= req_ready_1 ? req_b_1  : req_b_0;
                        r_op         <= req_ready_1 ? req_op_1 : req_op_0;
                        r_owner      <= req_ready_1;
                        r_last_grant <= req_ready_1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result       <= w_alu_result;
                    r_flags        <= w_alu_flags;
                    r_err          <= op_is_invalid(r_op);
                    r_resp_valid_0 <= ~r_owner;
                    r_resp_valid_1 <= r_owner;
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_resp_take) begin
                        r_resp_valid_0 <= 1'b0;
                        r_resp_valid_1 <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid_0 <= 1'b0;
                    r_resp_valid_1 <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_0 = r_resp_valid_0;
    assign resp_valid_1 = r_resp_valid_1;
    assign resp_result  = r_result;
    assign resp_flags   = r_flags;
    assign resp_err     = r_err;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_alu_share_ctrl                                                          |
// | Self-checking bench: vector table, scoreboard and multi-cycle sequences.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic [2:0]  req_op_0 = '0, req_op_1 = '0;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0 = 1'b1, resp_ready_1 = 1'b1;
    logic [31:0] resp_result;
    logic [3:0]  resp_flags;
    logic        resp_err;
    logic        busy;

    alu_share_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_0  (req_valid_0),
        .req_valid_1  (req_valid_1),
        .req_ready_0  (req_ready_0),
        .req_ready_1  (req_ready_1),
        .req_a_0      (req_a_0),
        .req_b_0      (req_b_0),
        .req_a_1      (req_a_1),
        .req_b_1      (req_b_1),
        .req_op_0     (req_op_0),
        .req_op_1     (req_op_1),
        .resp_valid_0 (resp_valid_0),
        .resp_valid_1 (resp_valid_1),
        .resp_ready_0 (resp_ready_0),
        .resp_ready_1 (resp_ready_1),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } sb_t;

    vec_t        vecs [10];
    sb_t         sb [$];
    sb_t         exp0, exp1;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (req_valid_0 && req_ready_0) sb.push_back(exp0);
            if (req_valid_1 && req_ready_1) sb.push_back(exp1);
            if (resp_valid_0 && resp_valid_1) chk("resp_valid_exclusive", 32'd1, 32'd0);
            if ((resp_valid_0 && resp_ready_0) || (resp_valid_1 && resp_ready_1)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("resp_port",   resp_valid_1 ? 32'd1 : 32'd0, e.port);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_flags",  {28'd0, resp_flags}, {28'd0, e.flg});
                    chk("resp_err",    {31'd0, resp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] res,
                         input logic [3:0] flg, input logic err);
        if (p == 0) begin
            req_a_0 = a; req_b_0 = b; req_op_0 = op; req_valid_0 = 1'b1;
            exp0 = '{0, res, flg, err};
        end else begin
            req_a_1 = a; req_b_1 = b; req_op_1 = op; req_valid_1 = 1'b1;
            exp1 = '{1, res, flg, err};
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req_ready_0 : req_ready_1;
    endfunction

    function automatic logic rvld(input int p);
        return (p == 0) ? resp_valid_0 : resp_valid_1;
    endfunction

    task automatic wait_ready(input int p);
        int n = 0;
        #1;
        while (!rdy(p) && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk($sformatf("grant_port%0d", p), {31'd0, rdy(p)}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.port, v.a, v.b, v.op, v.res, v.flg, v.err);
        wait_ready(v.port);
        tick();
        if (v.port == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
        #1;
        chk("exec_no_resp", {31'd0, rvld(v.port)}, 32'd0);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        tick();
        #1;
        chk("latency_resp_valid", {31'd0, rvld(v.port)}, 32'd1);
        tick();
        #1;
        chk("back_to_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int prev;
        int n;

        vecs[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 4'b1010, 1'b0};
        vecs[1] = '{1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 4'b0000, 1'b0};
        vecs[2] = '{0, 32'h00000005, 32'h00000005, 3'b001, 32'h00000000, 4'b1010, 1'b0};
        vecs[3] = '{1, 32'h80000000, 32'h0000003F, 3'b101, 32'h00000001, 4'b0000, 1'b0};
        vecs[4] = '{0, 32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 4'b0101, 1'b0};
        vecs[5] = '{1, 32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 4'b0011, 1'b0};
        vecs[6] = '{0, 32'h00000005, 32'h00000003, 3'b110, 32'h00000000, 4'b1000, 1'b1};
        vecs[7] = '{1, 32'h80000001, 32'h00000004, 3'b100, 32'h00000010, 4'b0000, 1'b0};
        vecs[8] = '{0, 32'h00000000, 32'h00000000, 3'b011, 32'h00000000, 4'b1000, 1'b0};
        vecs[9] = '{1, 32'h00000000, 32'h00000001, 3'b001, 32'hFFFFFFFF, 4'b0100, 1'b0};

        // Reset state, with requests pending to prove ready is held low.
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        #12;
        chk("rst_req_ready_0", {31'd0, req_ready_0}, 32'd0);
        chk("rst_req_ready_1", {31'd0, req_ready_1}, 32'd0);
        chk("rst_resp_valid",  {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
        chk("rst_result",      resp_result, 32'd0);
        chk("rst_flags",       {28'd0, resp_flags}, 32'd0);
        chk("rst_err_busy",    {30'd0, resp_err, busy}, 32'd0);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Conflict: both ports held valid, grants must alternate starting at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(0, 32'd5, 32'd7, 3'b001, 32'hFFFFFFFE, 4'b0100, 1'b0);
        drive(1, 32'hF0, 32'h0F, 3'b011, 32'h000000FF, 4'b0000, 1'b0);
        g = 0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req_ready_0 || req_ready_1) && n < 20) begin
                tick();
                #1;
                n++;
            end
            chk("rr_single_ready", {30'd0, req_ready_1, req_ready_0} == 2'b11 ? 32'd1 : 32'd0, 32'd0);
            chk("rr_grant", req_ready_1 ? 32'd1 : (req_ready_0 ? 32'd0 : 32'd9), g);
            if (k > 0) chk("issue_interval", cyc - prev, 32'd3);
            prev = cyc;
            g = 1 - g;
            tick();
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (3) tick();

        // Backpressure on port 1 while port 0 waits.
        resp_ready_1 = 1'b0;
        drive(1, 32'h1, 32'h21, 3'b100, 32'h2, 4'b0000, 1'b0);
        wait_ready(1);
        tick();
        req_valid_1 = 1'b0;
        drive(0, 32'd2, 32'd3, 3'b000, 32'd5, 4'b0000, 1'b0);
        #1;
        chk("bp_exec_hold_ready", {31'd0, req_ready_0}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_resp_valid", {31'd0, resp_valid_1}, 32'd1);
            chk("bp_result",     resp_result, 32'h2);
            chk("bp_busy",       {31'd0, busy}, 32'd1);
            chk("bp_req_ready",  {30'd0, req_ready_1, req_ready_0}, 32'd0);
            tick();
        end
        resp_ready_1 = 1'b1;
        #1;
        chk("bp_no_bypass", {31'd0, req_ready_0}, 32'd0);
        tick();
        #1;
        chk("bp_idle_busy",   {31'd0, busy}, 32'd0);
        chk("bp_idle_valid",  {31'd0, resp_valid_1}, 32'd0);
        chk("bp_idle_accept", {31'd0, req_ready_0}, 32'd1);
        tick();
        req_valid_0 = 1'b0;
        repeat (3) tick();

        // Invalid op; only the non-owner signals ready.
        resp_ready_0 = 1'b0;
        drive(0, 32'h1234, 32'h55, 3'b111, 32'h0, 4'b1000, 1'b1);
        wait_ready(0);
        tick();
        req_valid_0 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("inv_resp_valid", {31'd0, resp_valid_0}, 32'd1);
            chk("inv_busy",       {31'd0, busy}, 32'd1);
            chk("inv_result",     resp_result, 32'h0);
            chk("inv_flags",      {28'd0, resp_flags}, 32'h8);
            chk("inv_err",        {31'd0, resp_err}, 32'd1);
            tick();
        end
        resp_ready_0 = 1'b1;
        tick();
        #1;
        chk("inv_idle", {31'd0, busy}, 32'd0);

        // Leave non-zero output registers ahead of the reset test.
        run_vec(vecs[9]);

        // Reset while in EXEC.
        drive(0, 32'd3, 32'd4, 3'b000, 32'd7, 4'b0000, 1'b0);
        wait_ready(0);
        tick();
        #2;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req_valid_1 = 1'b1;
        #1;
        chk("arst_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
        chk("arst_result",     resp_result, 32'd0);
        chk("arst_flags",      {28'd0, resp_flags}, 32'd0);
        chk("arst_err_busy",   {30'd0, resp_err, busy}, 32'd0);
        chk("arst_req_ready",  {30'd0, req_ready_1, req_ready_0}, 32'd0);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_resp", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
        end
        drive(0, 32'd1, 32'd1, 3'b000, 32'd2, 4'b0000, 1'b0);
        drive(1, 32'hFF, 32'h0F, 3'b010, 32'h0F, 4'b0000, 1'b0);
        wait_ready(0);
        chk("arst_conflict_not_1", {31'd0, req_ready_1}, 32'd0);
        tick();
        req_valid_0 = 1'b0;
        wait_ready(1);
        tick();
        req_valid_1 = 1'b0;
        repeat (4) tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Round-robin controller that shares a single `alu` instance between two requesters. Each requester issues operations over a valid/ready request channel and receives its result and flags over a valid/ready response channel. The block registers operands, sequences the ALU through a 3-state FSM and holds the result until the owning requester takes it. It sits between the issue logic and the shared ALU datapath.

## Interface
- `WIDTH`, default 32: operand/result width, passed to `alu`.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_0` / `req_valid_1`  in  1  request present on port 0 / 1.
- `req_ready_0` / `req_ready_1`  out  1  request accepted this cycle.
- `req_a_0`, `req_b_0`, `req_a_1`, `req_b_1`  in  WIDTH  operands.
- `req_op_0` / `req_op_1`  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL.
- `resp_valid_0` / `resp_valid_1`  out  1  response present for port 0 / 1.
- `resp_ready_0` / `resp_ready_1`  in  1  requester accepts response.
- `resp_result`  out  WIDTH  result, shared by both ports, meaningful when either `resp_valid_*` is high.
- `resp_flags`  out  4  {Z,N,C,O} captured from the ALU.
- `resp_err`  out  1  op code 110/111 was issued.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **States:** IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among the asserted `req_valid_*`.
  - With a single valid, that port wins.
  - With both valid, the port not granted last wins.
  - `req_ready_k` = IDLE & winner==k. Ready may depend on valid.
  - On handshake: capture a, b and op into the operand register, record `owner`=k and `last_grant`=k, then go to EXEC.
- **EXEC**
  - Operand register drives `alu`.
  - Capture result, flags {Z,N,C,O} and `err` into the output register.
  - `err` = (op==110 | op==111). For those ops the ALU yields result 0 and flags 1000.
  - Go to RESP.
- **RESP**
  - `resp_valid_owner`=1; the other `resp_valid` stays 0.
  - Output register is held stable until `resp_ready_owner`.
  - On handshake, go to IDLE. Neither `req_ready` is asserted in this cycle (no bypass).
- **Boundary rules**
  - `last_grant` updates only on an accepted request.
  - Requests arriving while busy are held off by ready=0 and must stay stable (standard valid/ready).
  - `resp_ready` from the non-owner is ignored.
  - `resp_ready` asserted in IDLE or EXEC has no effect.
  - Shift amount is `b[$clog2(WIDTH)-1:0]`. Upper bits of b are ignored.
  - C on SUB = NOT borrow.

## Timing
- **Reset values**
  - state=IDLE, `last_grant`=1, so port 0 wins the first conflict.
  - `resp_valid_*`=0, `resp_result`=0, `resp_flags`=0, `resp_err`=0, `busy`=0.
  - `req_ready_*`=0 while `rst` is high.
- **Latency:** request accepted in cycle T, EXEC in T+1, `resp_valid` high from T+2.
- **Throughput:** with `resp_ready` already high, the next request is accepted in T+3. Minimum issue interval is 3 cycles.
- All outputs except `req_ready_*` are registered. `req_ready_*` is combinational from state, `last_grant` and `req_valid_*`.
- **Reset mid-operation:** asynchronous return to IDLE. The in-flight operation is dropped with no response. `resp_valid` falls immediately.

## Structure
- **Shared package `alu_pkg`:**
  - op-code localparams `ALU_ADD`…`ALU_SRL`.
  - flag bit indices `FLG_Z=3`, `FLG_N=2`, `FLG_C=1`, `FLG_O=0`.
  - FSM state encoding.
- **Sub-module:** one instance of the existing `alu` (WIDTH passed through), driven from the operand register.
- No other sub-modules. The round-robin logic is inline, since it covers only 2 ports.

## Test plan
1. **Reset and port-0 ADD.** After reset, port 0 issues ADD a=0xFFFFFFFF, b=1. Required: `req_ready_0` in T; `resp_valid_0` in T+2; result 0x00000000; flags Z=1 N=0 C=1 O=0; `resp_err`=0.
2. **Conflict and fairness.** Both ports hold valid from reset with back-to-back ops (port 0 SUB 5−7, port 1 OR 0xF0|0x0F). Required:
   - Grants alternate 0,1,0,1.
   - Port 0 response: 0xFFFFFFFE, N=1, C=0.
   - Port 1 response: 0x000000FF, Z=0.
3. **Response backpressure.** Port 1 issues SLL a=1, b=0x21; hold `resp_ready_1`=0 for 5 cycles. Required:
   - result 0x00000002 (shift 1) held stable throughout.
   - `busy`=1 and both `req_ready`=0 throughout.
   - IDLE the cycle after `resp_ready_1` rises.
4. **Invalid op and wrong-port ready.** Port 0 issues op 111 while `resp_ready_1`=1 and `resp_ready_0`=0. Required: result 0, flags 1000, `resp_err`=1, FSM stays in RESP.
5. **Signed overflow.** ADD 0x7FFFFFFF+1 → 0x80000000, O=1, N=1, C=0. SUB 0x80000000−1 → 0x7FFFFFFF, O=1, C=1.
6. **Reset in EXEC.** Assert `rst` during EXEC. Required:
   - All outputs return to reset values asynchronously.
   - No response after release.
   - The next conflict is granted to port 0.
